// File: rtl/axi_wr_burst_master.sv
// AXI4 write-path master: splits a local write request into INCR bursts fed from a show-ahead FIFO.
// Define AXI_4K_SPLIT_EN to keep every burst inside a single 4 KiB page.
module axi_wr_burst_master #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned LEN_W     = 11,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_adrs,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_ready,
    output logic              wr_fifo_re,
    input  logic [DATA_W-1:0] wr_fifo_data,
    input  logic              wr_fifo_empty,
    output logic              wr_done,
    output logic              wr_err
);

    localparam int unsigned BYTES = DATA_W / 8;

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [8:0]        burst_q, burst_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic              start_burst;

    // Only bresp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    logic unused_bresp0;
    assign unused_bresp0 = m_axi_bresp[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    assign m_axi_awvalid = (state_q == StAw);
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = m_axi_awvalid ? 8'(burst_q - 9'd1) : 8'd0;
    assign m_axi_wvalid  = (state_q == StW) & ~wr_fifo_empty;
    assign m_axi_wdata   = wr_fifo_data;
    assign m_axi_wlast   = (beat_cnt_q == 9'd1) & m_axi_wvalid;
    assign wr_fifo_re    = m_axi_wvalid & m_axi_wready;
    assign m_axi_bready  = (state_q == StB);
    assign wr_ready      = (state_q == StIdle);
    assign wr_done       = (state_q == StDone);
    assign wr_err        = err_q;

    always_comb begin : p_next
        int unsigned b;
`ifdef AXI_4K_SPLIT_EN
        int unsigned room;
        room = 0;
`endif
        b           = 0;
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        start_burst = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_start) begin
                    cur_addr_d  = wr_adrs;
                    remaining_d = wr_len;
                    err_d       = 1'b0;
                    if (wr_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StAw;
                        start_burst = 1'b1;
                    end
                end
            end
            StAw: begin
                if (m_axi_awready) begin
                    state_d    = StW;
                    beat_cnt_d = burst_q;
                end
            end
            StW: begin
                if (wr_fifo_re) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (beat_cnt_q == 9'd1) begin
                        state_d = StB;
                    end
                end
            end
            StB: begin
                if (m_axi_bvalid) begin
                    err_d       = err_q | m_axi_bresp[1];
                    remaining_d = remaining_q - LEN_W'(burst_q);
                    cur_addr_d  = cur_addr_q + ADDR_W'(32'(burst_q) * BYTES);
                    if (remaining_d == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StAw;
                        start_burst = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Burst length is fixed when the AW phase is entered and held until the B response.
        if (start_burst) begin
            b = 32'(remaining_d);
            if (b > MAX_BURST) begin
                b = MAX_BURST;
            end
`ifdef AXI_4K_SPLIT_EN
            room = (32'd4096 - 32'(cur_addr_d[11:0])) / BYTES;
            if (b > room) begin
                b = room;
            end
`endif
            burst_d = 9'(b);
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Self-checking bench for axi_wr_burst_master: directed cases plus randomized transfers
// checked against an arithmetic burst-plan model and a cycle-level AXI protocol monitor.
module tb_axi_wr_burst_master;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 28;
    localparam int LEN_W     = 11;
    localparam int MAX_BURST = 16;
    localparam int BYTES     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_adrs;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_ready;
    logic              wr_fifo_re;
    logic [DATA_W-1:0] wr_fifo_data;
    logic              wr_fifo_empty;
    logic              wr_done;
    logic              wr_err;

    always #5 clk = ~clk;

    axi_wr_burst_master #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .wr_start     (wr_start),
        .wr_adrs      (wr_adrs),
        .wr_len       (wr_len),
        .wr_ready     (wr_ready),
        .wr_fifo_re   (wr_fifo_re),
        .wr_fifo_data (wr_fifo_data),
        .wr_fifo_empty(wr_fifo_empty),
        .wr_done      (wr_done),
        .wr_err       (wr_err)
    );

    int errors = 0;
    int checks = 0;

    // Environment knobs
    int   fifo_mode  = 0;     // 0 always full, 1 toggling empty, 2 random empty
    bit   rand_ready = 1'b0;
    int   aw_stall   = 0;
    logic [1:0] bresp_plan [256];

    // Monitor / model state
    bit          w_open = 1'b0;
    int          beat_idx = 0;
    int          cur_len = 0;
    int          pending_b = 0;
    int          b_idx = 0;
    int          pops = 0;
    int          done_cnt = 0;
    int          head = 0;
    bit          pop_flag = 1'b0;
    bit          prev_stall = 1'b0;
    bit          toggle = 1'b0;
    logic [27:0] prev_addr;
    logic [7:0]  prev_len;
    logic [27:0] got_addr [$];
    int          got_len [$];

    function automatic logic [127:0] word(input int i);
        return {4{32'(i) ^ 32'hA5A5_0000}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave / FIFO driver: updates inputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_flag) begin
                head++;
                pop_flag = 1'b0;
            end
            wr_fifo_data = word(head);
            if (fifo_mode == 1) begin
                toggle        = ~toggle;
                wr_fifo_empty = toggle;
            end else if (fifo_mode == 2) begin
                wr_fifo_empty = ($urandom_range(0, 2) == 0);
            end else begin
                wr_fifo_empty = 1'b0;
            end
            if (aw_stall > 0 && m_axi_awvalid) begin
                aw_stall--;
                m_axi_awready = 1'b0;
            end else begin
                m_axi_awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            m_axi_wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_bvalid = (pending_b > 0) && (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
            m_axi_bresp  = m_axi_bvalid ? bresp_plan[b_idx % 256] : 2'b00;
        end
    end

    // Protocol monitor: samples on the falling edge, i.e. what the next rising edge will commit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("re_is_w_handshake", wr_fifo_re, m_axi_wvalid & m_axi_wready);
                if (w_open) begin
                    chk("wvalid_follows_fifo", m_axi_wvalid, !wr_fifo_empty);
                    chk("wlast", m_axi_wlast, m_axi_wvalid && (beat_idx == cur_len));
                    chk("aw_while_w_open", m_axi_awvalid, 1'b0);
                end else begin
                    chk("w_without_aw", m_axi_wvalid, 1'b0);
                end
                if (prev_stall) begin
                    chk("aw_hold_valid", m_axi_awvalid, 1'b1);
                    chk("aw_hold_addr", m_axi_awaddr, prev_addr);
                    chk("aw_hold_len", m_axi_awlen, prev_len);
                end
                prev_stall = m_axi_awvalid && !m_axi_awready;
                prev_addr  = m_axi_awaddr;
                prev_len   = m_axi_awlen;
                if (m_axi_awvalid && m_axi_awready) begin
                    got_addr.push_back(m_axi_awaddr);
                    got_len.push_back(int'(m_axi_awlen));
                    w_open   = 1'b1;
                    beat_idx = 0;
                    cur_len  = int'(m_axi_awlen);
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    chk("wdata", m_axi_wdata, word(head));
                    pops++;
                    pop_flag = 1'b1;
                    if (m_axi_wlast) begin
                        w_open = 1'b0;
                        pending_b++;
                    end else begin
                        beat_idx++;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    pending_b--;
                    b_idx++;
                end
                if (wr_done) done_cnt++;
            end
        end
    end

    task automatic run_xfer(input logic [27:0] adrs, input int len, input string tag);
        logic [27:0] a;
        logic [27:0] ea [$];
        int          el [$];
        int          rem, b, n, cyc, room;
        bit          exp_err, seen;
        // Reference plan: chop the request into bursts with plain arithmetic.
        a = adrs; rem = len; n = 0; exp_err = 1'b0; room = 0;
        while (rem > 0) begin
            b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef AXI_4K_SPLIT_EN
            room = (4096 - (int'(a) % 4096)) / BYTES;
            if (b > room) b = room;
`endif
            ea.push_back(a);
            el.push_back(b - 1);
            if (bresp_plan[n][1]) exp_err = 1'b1;
            n++;
            rem -= b;
            a = a + 28'(b * BYTES);
        end
        got_addr.delete();
        got_len.delete();
        pops = 0; done_cnt = 0; b_idx = 0;
        cyc = 0;
        while (!wr_ready && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, ":ready"}, wr_ready, 1'b1);
        wr_adrs  = adrs;
        wr_len   = 11'(len);
        wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start = 1'b0;
        chk({tag, ":err_cleared"}, wr_err, 1'b0);
        seen = 1'b0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (wr_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, ":done_seen"}, seen, 1'b1);
        if (seen) chk({tag, ":err_at_done"}, wr_err, exp_err);
        if (len == 0) chk({tag, ":zero_len_latency"}, cyc, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ":done_pulses"}, done_cnt, 1);
        chk({tag, ":done_low"}, wr_done, 1'b0);
        chk({tag, ":ready_after"}, wr_ready, 1'b1);
        chk({tag, ":err_held"}, wr_err, exp_err);
        chk({tag, ":aw_count"}, got_addr.size(), n);
        chk({tag, ":pops"}, pops, len);
        if (got_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, ":aw_addr"}, got_addr[i], ea[i]);
                chk({tag, ":aw_len"}, got_len[i], el[i]);
            end
        end
    endtask

    initial begin
        int cyc;
        logic [27:0] ra;
        wr_start = 1'b0; wr_adrs = '0; wr_len = '0;
        wr_fifo_empty = 1'b1; wr_fifo_data = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        for (int i = 0; i < 256; i++) bresp_plan[i] = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst:wr_ready", wr_ready, 1'b1);
        chk("rst:awvalid", m_axi_awvalid, 1'b0);
        chk("rst:wvalid", m_axi_wvalid, 1'b0);
        chk("rst:bready", m_axi_bready, 1'b0);
        chk("rst:wr_done", wr_done, 1'b0);
        chk("rst:wr_err", wr_err, 1'b0);
        chk("rst:fifo_re", wr_fifo_re, 1'b0);
        chk("rst:awaddr", m_axi_awaddr, 28'h0);
        chk("rst:awlen", m_axi_awlen, 8'h0);
        rst_n = 1'b1;

        // Multi-burst transfer, everything ready
        run_xfer(28'h100, 40, "t1");
        if (got_addr.size() == 3) begin
            chk("t1:aw0", {got_addr[0], 8'(got_len[0])}, {28'h100, 8'd15});
            chk("t1:aw1", {got_addr[1], 8'(got_len[1])}, {28'h200, 8'd15});
            chk("t1:aw2", {got_addr[2], 8'(got_len[2])}, {28'h300, 8'd7});
        end

        // Single beat, then zero length
        run_xfer(28'h40, 1, "t2a");
        if (got_len.size() == 1) chk("t2a:awlen0", got_len[0], 0);
        run_xfer(28'h80, 0, "t2b");

        // FIFO empty toggling every cycle
        fifo_mode = 1;
        run_xfer(28'h0, 16, "t3");
        fifo_mode = 0;

        // AW stall plus error response on the middle burst
        aw_stall = 5;
        bresp_plan[1] = 2'b10;
        run_xfer(28'h2000, 48, "t4");
        repeat (3) @(posedge clk);
        #1;
        chk("t4:err_sticky_idle", wr_err, 1'b1);
        bresp_plan[1] = 2'b00;
        run_xfer(28'h3000, 4, "t4b");

        // Transfer straddling a 4 KiB boundary
        run_xfer(28'hFC0, 16, "t5");
`ifdef AXI_4K_SPLIT_EN
        if (got_addr.size() == 2) begin
            chk("t5:aw0", {got_addr[0], 8'(got_len[0])}, {28'hFC0, 8'd3});
            chk("t5:aw1", {got_addr[1], 8'(got_len[1])}, {28'h1000, 8'd11});
        end
`else
        if (got_addr.size() == 1) chk("t5:aw0", {got_addr[0], 8'(got_len[0])}, {28'hFC0, 8'd15});
`endif

        // Reset during the W phase
        wr_adrs = 28'h4000; wr_len = 11'd32; wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start = 1'b0;
        cyc = 0;
        while (!m_axi_wvalid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("t6:reached_w", m_axi_wvalid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6:awvalid", m_axi_awvalid, 1'b0);
        chk("t6:wvalid", m_axi_wvalid, 1'b0);
        chk("t6:wr_done", wr_done, 1'b0);
        chk("t6:wr_ready", wr_ready, 1'b1);
        chk("t6:bready", m_axi_bready, 1'b0);
        w_open = 1'b0; pending_b = 0; b_idx = 0; pop_flag = 1'b0; prev_stall = 1'b0; aw_stall = 0;
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk("t6:no_done_in_reset", done_cnt, 0);
        run_xfer(28'h5000, 20, "t6b");

        // Randomized transfers with random handshakes, FIFO gaps and responses
        rand_ready = 1'b1;
        fifo_mode  = 2;
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 256; i++) begin
                bresp_plan[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3))
                                                            : 2'($urandom_range(0, 1));
            end
            ra = 28'($urandom) & 28'hFFFFFF0;
            if (t % 3 == 0) ra = {ra[27:12], 12'hF00} + 28'({$urandom_range(0, 15), 4'h0});
            if (t == 5) ra = 28'hFFFFF80;
            run_xfer(ra, $urandom_range(0, 100), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
